// File: rtl/mux_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_ctrl_if
// Purpose  : Bundles the start/sample/select/result signals between the scan
//            sequencer and its surroundings (requester and 4-to-1 mux).
// Signals  : i_start - scan request level
//            i_mux   - output of the downstream 4-to-1 mux
//            o_s0    - mux select bit 0 (registered)
//            o_s1    - mux select bit 1 (registered)
//            o_busy  - high while a scan is running
//            o_done  - one-cycle pulse when a scan completes
//            o_word  - last completed scan, bit n sampled with {S1,S0}=n
// Modports : master - requester / mux side (drives i_start, i_mux)
//            slave  - the sequencer (drives o_*)
// Revision : 1.0 - initial release
// ============================================================================
interface mux_scan_ctrl_if;
  logic       i_start;
  logic       i_mux;
  logic       o_s0;
  logic       o_s1;
  logic       o_busy;
  logic       o_done;
  logic [3:0] o_word;

  modport master (
    output i_start,
    output i_mux,
    input  o_s0,
    input  o_s1,
    input  o_busy,
    input  o_done,
    input  o_word
  );

  modport slave (
    input  i_start,
    input  i_mux,
    output o_s0,
    output o_s1,
    output o_busy,
    output o_done,
    output o_word
  );
endinterface : mux_scan_ctrl_if
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_ctrl
// Purpose  : Steps the select lines of a downstream 4-to-1 mux through
//            channels 0..3, holding each for DWELL cycles, samples the mux
//            output on the last cycle of each dwell and publishes the four
//            samples as one word together with a one-cycle done pulse.
// Ports    : clk - rising-edge clock
//            rst - asynchronous, active-high reset
//            bus - mux_scan_ctrl_if.slave (start, mux sample, selects,
//                  busy, done, result word)
// Params   : DWELL - cycles each select value is held (legal 1..255)
// Options  : CONTINUOUS_SCAN_EN - when defined, a start request seen in DONE
//            re-enters SCAN directly and no re-arming is needed; when
//            undefined, DONE always returns to IDLE and Start must be seen
//            low once before another scan is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Terminal value of the dwell counter; the sample is taken when cnt hits it.
  localparam logic [7:0] c_DWELL_LAST = 8'(DWELL - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_ch;
  logic [1:0] w_ch_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [3:0] r_shd;
  logic [3:0] w_shd_nxt;
  logic [3:0] r_word;
  logic [3:0] w_word_nxt;
  logic       w_start_ok;

`ifndef CONTINUOUS_SCAN_EN
  // Set once Start has been observed low; cleared when a scan is accepted,
  // so a Start held high produces exactly one scan.
  logic       r_armed;
  logic       w_armed_nxt;
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ch    <= 2'd0;
      r_cnt   <= 8'd0;
      r_shd   <= 4'd0;
      r_word  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shd   <= w_shd_nxt;
      r_word  <= w_word_nxt;
    end
  end

`ifndef CONTINUOUS_SCAN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b1;
    end else begin
      r_armed <= w_armed_nxt;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = r_cnt;
    w_shd_nxt   = r_shd;
    w_word_nxt  = r_word;

`ifdef CONTINUOUS_SCAN_EN
    w_start_ok  = bus.i_start;
`else
    w_start_ok  = bus.i_start & r_armed;
    w_armed_nxt = r_armed | ~bus.i_start;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = ST_SCAN;
          w_ch_nxt    = 2'd0;
          w_cnt_nxt   = 8'd0;
          w_shd_nxt   = 4'd0;
`ifndef CONTINUOUS_SCAN_EN
          w_armed_nxt = 1'b0;
`endif
        end
      end

      ST_SCAN: begin
        if (r_cnt < c_DWELL_LAST) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end else begin
          // Last cycle of the dwell: the mux has long settled on r_ch.
          w_cnt_nxt       = 8'd0;
          w_shd_nxt[r_ch] = bus.i_mux;
          if (r_ch == 2'd3) begin
            // Publish the whole word at once; the shadow is never exposed.
            w_word_nxt  = {bus.i_mux, r_shd[2:0]};
            w_ch_nxt    = 2'd0;
            w_state_nxt = ST_DONE;
          end else begin
            w_ch_nxt = r_ch + 2'd1;
          end
        end
      end

      ST_DONE: begin
`ifdef CONTINUOUS_SCAN_EN
        if (bus.i_start) begin
          w_state_nxt = ST_SCAN;
          w_ch_nxt    = 2'd0;
          w_cnt_nxt   = 8'd0;
          w_shd_nxt   = 4'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_ch_nxt    = 2'd0;
        w_cnt_nxt   = 8'd0;
        w_shd_nxt   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: selects come straight from the channel register; busy/done are
  // decodes of the state register.
  // --------------------------------------------------------------------------
  assign bus.o_s0   = r_ch[0];
  assign bus.o_s1   = r_ch[1];
  assign bus.o_busy = (r_state == ST_SCAN);
  assign bus.o_done = (r_state == ST_DONE);
  assign bus.o_word = r_word;

endmodule : mux_scan_ctrl
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_ctrl
// Purpose  : Directed self-checking bench for mux_scan_ctrl with DWELL=4.
//            Models the downstream 4-to-1 mux from four bench inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_in, b_in, c_in, d_in;
  logic [1:0] sel;
  int errors = 0;
  int checks = 0;

  mux_scan_ctrl_if ifc();

  mux_scan_ctrl #(.DWELL(D)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  assign sel = {ifc.o_s1, ifc.o_s0};
  assign ifc.i_mux = (sel == 2'd0) ? a_in :
                     (sel == 2'd1) ? b_in :
                     (sel == 2'd2) ? c_in : d_in;

  // Each call lands mid-cycle; inputs set here are sampled at the next edge.
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_gap(input int n);
    ifc.i_start = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sel, ifc.o_busy, ifc.o_done, ifc.o_word} !== 8'h00) begin
      errors++;
      $display("FAIL reset_async got=%b exp=00000000",
               {sel, ifc.o_busy, ifc.o_done, ifc.o_word});
    end
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if ({sel, ifc.o_busy, ifc.o_done, ifc.o_word} !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle c=%0d got=%b exp=00000000", c,
                 {sel, ifc.o_busy, ifc.o_done, ifc.o_word});
      end
    end
  endtask

  task automatic test_single_scan;
    logic       exp_busy, exp_done;
    logic [1:0] exp_sel;
    logic [3:0] exp_word;
    a_in = 1'b1; b_in = 1'b0; c_in = 1'b0; d_in = 1'b0;
    idle_gap(2);
    ifc.i_start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      ifc.i_start = 1'b0;
      exp_busy = (c <= 4 * D);
      exp_done = (c == 4 * D + 1);
      exp_sel  = (c <= 4 * D) ? 2'((c - 1) / D) : 2'd0;
      exp_word = (c >= 4 * D + 1) ? 4'b0001 : 4'b0000;
      checks += 4;
      if (ifc.o_busy !== exp_busy) begin
        errors++;
        $display("FAIL single_busy c=%0d got=%b exp=%b", c, ifc.o_busy, exp_busy);
      end
      if (ifc.o_done !== exp_done) begin
        errors++;
        $display("FAIL single_done c=%0d got=%b exp=%b", c, ifc.o_done, exp_done);
      end
      if (sel !== exp_sel) begin
        errors++;
        $display("FAIL single_sel c=%0d got=%0d exp=%0d", c, sel, exp_sel);
      end
      if (ifc.o_word !== exp_word) begin
        errors++;
        $display("FAIL single_word c=%0d got=%b exp=%b", c, ifc.o_word, exp_word);
      end
    end
  endtask

  task automatic test_late_sampling;
    a_in = 1'b0; b_in = 1'b0; c_in = 1'b0; d_in = 1'b0;
    idle_gap(2);
    ifc.i_start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      ifc.i_start = 1'b0;
      // C high only on the first cycle of channel 2, D only on the last of 3.
      c_in = (c == 2 * D + 1);
      d_in = (c == 4 * D);
      if (c == 2 * D + 1 || c == 4 * D) begin
        checks++;
        if (sel !== ((c == 4 * D) ? 2'd3 : 2'd2)) begin
          errors++;
          $display("FAIL late_sel c=%0d got=%0d", c, sel);
        end
      end
      if (c < 4 * D + 1) begin
        checks++;
        if (ifc.o_word !== 4'b0001) begin
          errors++;
          $display("FAIL late_hold c=%0d got=%b exp=0001", c, ifc.o_word);
        end
      end
      if (c == 4 * D + 1) begin
        checks += 2;
        if (ifc.o_done !== 1'b1) begin
          errors++;
          $display("FAIL late_done c=%0d got=%b exp=1", c, ifc.o_done);
        end
        if (ifc.o_word !== 4'b1000) begin
          errors++;
          $display("FAIL late_word got=%b exp=1000", ifc.o_word);
        end
      end
    end
    c_in = 1'b0; d_in = 1'b0;
  endtask

  task automatic test_start_ignored;
    int ndone = 0;
    int done_c = -1;
    a_in = 1'b0; b_in = 1'b1; c_in = 1'b0; d_in = 1'b0;
    idle_gap(2);
    ifc.i_start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
`ifdef CONTINUOUS_SCAN_EN
      ifc.i_start = (c == 5);
`else
      ifc.i_start = (c == 5) || (c == 4 * D + 1);
`endif
      if (ifc.o_done === 1'b1) begin
        ndone++;
        done_c = c;
      end
    end
    checks += 3;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignored_count got=%0d exp=1", ndone);
    end
    if (done_c !== 4 * D + 1) begin
      errors++;
      $display("FAIL ignored_cycle got=%0d exp=%0d", done_c, 4 * D + 1);
    end
    if (ifc.o_word !== 4'b0010) begin
      errors++;
      $display("FAIL ignored_word got=%b exp=0010", ifc.o_word);
    end
  endtask

`ifndef CONTINUOUS_SCAN_EN
  task automatic test_held_start;
    int ndone = 0;
    int done_c = -1;
    a_in = 1'b1; b_in = 1'b0; c_in = 1'b1; d_in = 1'b0;
    idle_gap(2);
    ifc.i_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ifc.o_done === 1'b1) begin
        ndone++;
        done_c = c;
      end
    end
    checks += 2;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL held_count got=%0d exp=1", ndone);
    end
    if (done_c !== 4 * D + 1) begin
      errors++;
      $display("FAIL held_cycle got=%0d exp=%0d", done_c, 4 * D + 1);
    end
    tick();                 // cycle 41: drop Start for one cycle to re-arm
    ifc.i_start = 1'b0;
    tick();                 // cycle 42: raise Start again
    ifc.i_start = 1'b1;
    for (int c = 43; c <= 60; c++) begin
      tick();
      checks += 2;
      if (ifc.o_busy !== (c <= 42 + 4 * D)) begin
        errors++;
        $display("FAIL rearm_busy c=%0d got=%b", c, ifc.o_busy);
      end
      if (ifc.o_done !== (c == 43 + 4 * D)) begin
        errors++;
        $display("FAIL rearm_done c=%0d got=%b", c, ifc.o_done);
      end
      if (c == 43 + 4 * D) begin
        checks++;
        if (ifc.o_word !== 4'b0101) begin
          errors++;
          $display("FAIL rearm_word got=%b exp=0101", ifc.o_word);
        end
      end
    end
    ifc.i_start = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_scan;
    int ndone = 0;
    a_in = 1'b0; b_in = 1'b1; c_in = 1'b0; d_in = 1'b1;
    idle_gap(2);
    ifc.i_start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      ifc.i_start = 1'b0;
    end
    checks++;
    if (ifc.o_word !== 4'b1010) begin
      errors++;
      $display("FAIL midrst_prior got=%b exp=1010", ifc.o_word);
    end
    idle_gap(2);
    ifc.i_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      ifc.i_start = 1'b0;
    end
    checks++;
    if (ifc.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_running got=%b exp=1", ifc.o_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({sel, ifc.o_busy, ifc.o_done, ifc.o_word} !== 8'h00) begin
      errors++;
      $display("FAIL midrst_clear got=%b exp=00000000",
               {sel, ifc.o_busy, ifc.o_done, ifc.o_word});
    end
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ifc.o_done === 1'b1) ndone++;
      checks++;
      if (ifc.o_word !== 4'b0000 || ifc.o_busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_after c=%0d word=%b busy=%b exp word=0000 busy=0",
                 c, ifc.o_word, ifc.o_busy);
      end
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL midrst_done got=%0d exp=0", ndone);
    end
  endtask

`ifdef CONTINUOUS_SCAN_EN
  task automatic test_continuous;
    logic exp_done, exp_busy;
    a_in = 1'b0; b_in = 1'b1; c_in = 1'b0; d_in = 1'b1;
    idle_gap(2);
    ifc.i_start = 1'b1;
    for (int c = 1; c <= 53; c++) begin
      tick();
      if (c == 50) ifc.i_start = 1'b0;
      exp_done = (c == 17) || (c == 34) || (c == 51);
      exp_busy = (c <= 50) && (c % 17 != 0);
      checks += 2;
      if (ifc.o_done !== exp_done) begin
        errors++;
        $display("FAIL cont_done c=%0d got=%b exp=%b", c, ifc.o_done, exp_done);
      end
      if (ifc.o_busy !== exp_busy) begin
        errors++;
        $display("FAIL cont_busy c=%0d got=%b exp=%b", c, ifc.o_busy, exp_busy);
      end
      if (exp_done) begin
        checks++;
        if (ifc.o_word !== 4'b1010) begin
          errors++;
          $display("FAIL cont_word c=%0d got=%b exp=1010", c, ifc.o_word);
        end
      end
    end
  endtask
`endif

  initial begin
    ifc.i_start = 1'b0;
    a_in = 1'b0; b_in = 1'b0; c_in = 1'b0; d_in = 1'b0;
    test_reset();
    test_single_scan();
    test_late_sampling();
    test_start_ignored();
`ifndef CONTINUOUS_SCAN_EN
    test_held_start();
`endif
    test_reset_mid_scan();
`ifdef CONTINUOUS_SCAN_EN
    test_continuous();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule : tb_mux_scan_ctrl
`default_nettype wire
